decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipeline stage that consumes the fetch stage's valid/ready output: instruction word, PC and PC+4.
- Decodes each RV32I instruction into register indices, a sign-extended immediate, a functional-unit class and control flags.
- Holds decoded micro-ops in a small skid buffer, so the upstream ready is registered and never combinational from downstream ready.
- Sits between fetch and rename/dispatch in the out-of-order core.

Parameters:
DEPTH, 2, skid-buffer entries (>=2); the occupancy counter is $clog2(DEPTH+1) bits wide.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (asserted at 0)
flush  input  1  synchronous pipeline flush (mispredict/redirect)
valid_in  input  1  fetch beat valid
ready_out  output  1  stage can accept a beat this cycle
instr_in  input  32  instruction word
pc_in  input  32  instruction PC
pc_4_in  input  32  PC+4 from fetch
valid_out  output  1  decoded micro-op valid at buffer head
ready_in  input  1  downstream accepts head this cycle
pc_out  output  32  head PC
pc_4_out  output  32  head PC+4
opcode  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7  output  7  instr[31:25]
rd  output  5  destination register
rs1  output  5  source 1
rs2  output  5  source 2
imm  output  32  sign-extended immediate
fu_type  output  2  0=ALU, 1=branch/jump, 2=load/store, 3=unused
uses_rs1  output  1  rs1 is a real source
uses_rs2  output  1  rs2 is a real source
writes_rd  output  1  instruction writes rd, and rd != 0
illegal  output  1  opcode not in the RV32I base set

Behaviour:
- Reset (reset==0, asynchronous): occupancy=0, head/tail pointers=0, all entry contents cleared.
  - valid_out=0, every data output=0, ready_out=1.
  - Reset asserted mid-operation discards all entries immediately.
- Push: valid_in && ready_out.
  - Decode is combinational from instr_in; the decoded result is written into the tail entry.
  - The beat is visible on the outputs no earlier than the next cycle (1-cycle latency when empty).
- Pop: valid_out && ready_in. Head advances.
- valid_out = (occupancy != 0). Outputs always reflect the head entry; when empty they hold the last value or 0.
- ready_out = (occupancy != DEPTH), from registered state only.
- Simultaneous push and pop: occupancy unchanged.
  - When full, a same-cycle pop does NOT enable a push, because ready_out is already 0.
- Upstream holds valid_in/data while ready_out=0 (fetch's contract). Decode must not depend on stability beyond the accepting cycle.
- flush=1: next cycle occupancy=0 and valid_out=0. A same-cycle push and pop are both discarded. Flush has priority over push/pop.
- Pointers wrap modulo DEPTH.
- Decode rules by opcode:
  - OP (0110011): R-type; uses_rs1=1, uses_rs2=1, imm=0, fu=ALU.
  - OP-IMM (0010011): I-type immediate; uses_rs1=1, fu=ALU.
  - LOAD (0000011): I-type immediate; uses_rs1=1, fu=LSU.
  - STORE (0100011): S-type immediate; uses_rs1=1, uses_rs2=1, writes_rd=0, fu=LSU.
  - BRANCH (1100011): B-type immediate; uses_rs1=1, uses_rs2=1, writes_rd=0, fu=BR.
  - JAL (1101111): J-type immediate; fu=BR, writes rd.
  - JALR (1100111): I-type immediate; uses_rs1=1, fu=BR.
  - LUI (0110111) / AUIPC (0010111): imm={instr[31:12],12'b0}, fu=ALU.
  - Any other opcode: illegal=1, writes_rd=0, uses_rs*=0, fu=ALU, imm=0. The entry still flows through the pipeline.
- B- and J-type immediates have bit 0 = 0. All immediates are sign-extended from instr[31].
- rs1/rs2/rd are always raw fields instr[19:15]/[24:20]/[11:7]; the uses_*/writes_rd flags qualify them.
- pc_4_out passes through from pc_4_in and is not recomputed.

Test Plan:
- Empty stage, ready_in=1, push 0x00500093 @pc=0x100 -> next cycle valid_out=1, rd=1, rs1=0, imm=5, fu_type=0, writes_rd=1, uses_rs2=0, pc_4_out=0x104.
- Push 0x0020A423 (sw x2,8(x1)) -> rs1=1, rs2=2, imm=8, fu_type=2, writes_rd=0, uses_rs2=1.
- Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, fu_type=1, writes_rd=0; push 0x123452B7 (lui x5) -> imm=0x12345000, rd=5.
- Hold ready_in=0 and push 3 beats -> ready_out drops to 0 after 2 accepts and the 3rd beat waits. Release ready_in -> beats emerge in order with one per cycle and none lost or duplicated.
- With 2 entries, assert flush together with valid_in -> next cycle valid_out=0, ready_out=1, and the flushed beat never appears. Push 0xFFFFFFFF -> illegal=1, writes_rd=0.
- Drop reset to 0 asynchronously mid-burst -> valid_out=0 and ready_out=1 without waiting for a clock edge. After release, the first push decodes correctly.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage with a DEPTH-entry skid buffer: 1-cycle latency when empty.
// ready_out depends only on registered occupancy; when full, a same-cycle pop does not admit a push.
module decode_stage #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic        valid_in,
   output logic        ready_out,
   input  logic [31:0] instr_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] pc_4_in,
   output logic        valid_out,
   input  logic        ready_in,
   output logic [31:0] pc_out,
   output logic [31:0] pc_4_out,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [31:0] imm,
   output logic [1:0]  fu_type,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        writes_rd,
   output logic        illegal
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_BR  = 2'd1;
   localparam logic [1:0] FU_LSU = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [1:0]  fu_type;
      logic        uses_rs1;
      logic        uses_rs2;
      logic        writes_rd;
      logic        illegal;
   } uop_t;

   uop_t          dec;
   uop_t          mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;
   logic          wr_en;

   always_comb begin
      dec        = '0;
      dec.pc     = pc_in;
      dec.pc_4   = pc_4_in;
      dec.opcode = instr_in[6:0];
      dec.funct3 = instr_in[14:12];
      dec.funct7 = instr_in[31:25];
      dec.rd     = instr_in[11:7];
      dec.rs1    = instr_in[19:15];
      dec.rs2    = instr_in[24:20];
      wr_en      = 1'b0;
      case (instr_in[6:0])
         OPC_OP: begin
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            wr_en        = 1'b1;
         end
         OPC_OP_IMM, OPC_LOAD: begin
            dec.uses_rs1 = 1'b1;
            dec.imm      = {{20{instr_in[31]}}, instr_in[31:20]};
            dec.fu_type  = (instr_in[6:0] == OPC_LOAD) ? FU_LSU : FU_ALU;
            wr_en        = 1'b1;
         end
         OPC_STORE: begin
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            dec.imm      = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
            dec.fu_type  = FU_LSU;
         end
         OPC_BRANCH: begin
            dec.uses_rs1 = 1'b1;
            dec.uses_rs2 = 1'b1;
            dec.imm      = {{19{instr_in[31]}}, instr_in[31], instr_in[7],
                            instr_in[30:25], instr_in[11:8], 1'b0};
            dec.fu_type  = FU_BR;
         end
         OPC_JAL: begin
            dec.imm     = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12],
                           instr_in[20], instr_in[30:21], 1'b0};
            dec.fu_type = FU_BR;
            wr_en       = 1'b1;
         end
         OPC_JALR: begin
            dec.uses_rs1 = 1'b1;
            dec.imm      = {{20{instr_in[31]}}, instr_in[31:20]};
            dec.fu_type  = FU_BR;
            wr_en        = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.imm = {instr_in[31:12], 12'b0};
            wr_en   = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.writes_rd = wr_en && (instr_in[11:7] != 5'd0);
   end

   assign ready_out = (count != CW'(DEPTH));
   assign valid_out = (count != '0);
   assign push      = valid_in && ready_out;
   assign pop       = valid_out && ready_in;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (push) begin
            mem[tail] <= dec;
            tail      <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
         end
         if (pop) head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // Outputs track the head entry; after a pop the stale entry stays visible but unqualified.
   assign pc_out    = mem[head].pc;
   assign pc_4_out  = mem[head].pc_4;
   assign opcode    = mem[head].opcode;
   assign funct3    = mem[head].funct3;
   assign funct7    = mem[head].funct7;
   assign rd        = mem[head].rd;
   assign rs1       = mem[head].rs1;
   assign rs2       = mem[head].rs2;
   assign imm       = mem[head].imm;
   assign fu_type   = mem[head].fu_type;
   assign uses_rs1  = mem[head].uses_rs1;
   assign uses_rs2  = mem[head].uses_rs2;
   assign writes_rd = mem[head].writes_rd;
   assign illegal   = mem[head].illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed and random checks of decode_stage against a queue-based reference model.
module tb_decode_stage;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] instr_in;
   logic [31:0] pc_in;
   logic [31:0] pc_4_in;
   logic        valid_out;
   logic        ready_in;
   logic [31:0] pc_out;
   logic [31:0] pc_4_out;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm;
   logic [1:0]  fu_type;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        writes_rd;
   logic        illegal;

   decode_stage #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .valid_in(valid_in), .ready_out(ready_out),
      .instr_in(instr_in), .pc_in(pc_in), .pc_4_in(pc_4_in),
      .valid_out(valid_out), .ready_in(ready_in),
      .pc_out(pc_out), .pc_4_out(pc_4_out),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .fu_type(fu_type),
      .uses_rs1(uses_rs1), .uses_rs2(uses_rs2),
      .writes_rd(writes_rd), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_4;
      logic [31:0] imm;
      int          fu;
      bit          u1;
      bit          u2;
      bit          wr;
      bit          ill;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Immediates built from signed shifts and weighted field sums.
   function automatic exp_t ref_dec(logic [31:0] ins, logic [31:0] pc, logic [31:0] pc4);
      exp_t e;
      int   s;
      bit   w;
      s = $signed(ins);
      w = 0;
      e.instr = ins; e.pc = pc; e.pc_4 = pc4;
      e.imm = 0; e.fu = 0; e.u1 = 0; e.u2 = 0; e.ill = 0;
      case (int'(ins[6:0]))
         'h33: begin e.u1 = 1; e.u2 = 1; w = 1; end
         'h13: begin e.u1 = 1; w = 1; e.imm = s >>> 20; end
         'h03: begin e.u1 = 1; w = 1; e.fu = 2; e.imm = s >>> 20; end
         'h23: begin e.u1 = 1; e.u2 = 1; e.fu = 2;
                     e.imm = (s >>> 25) * 32 + int'(ins[11:7]); end
         'h63: begin e.u1 = 1; e.u2 = 1; e.fu = 1;
                     e.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048
                           + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
         'h6F: begin w = 1; e.fu = 1;
                     e.imm = (s >>> 31) * (1 << 20) + int'(ins[19:12]) * 4096
                           + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
         'h67: begin e.u1 = 1; w = 1; e.fu = 1; e.imm = s >>> 20; end
         'h37, 'h17: begin w = 1; e.imm = ins & 32'hFFFF_F000; end
         default: e.ill = 1;
      endcase
      e.wr = w && (ins[11:7] != 5'd0);
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      exp_t h;
      chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
      chk("ready_out", 32'(ready_out), 32'(q.size() != DEPTH));
      if (q.size() != 0) begin
         h = q[0];
         chk("pc_out",    pc_out,           h.pc);
         chk("pc_4_out",  pc_4_out,         h.pc_4);
         chk("opcode",    32'(opcode),      32'(h.instr[6:0]));
         chk("funct3",    32'(funct3),      32'(h.instr[14:12]));
         chk("funct7",    32'(funct7),      32'(h.instr[31:25]));
         chk("rd",        32'(rd),          32'(h.instr[11:7]));
         chk("rs1",       32'(rs1),         32'(h.instr[19:15]));
         chk("rs2",       32'(rs2),         32'(h.instr[24:20]));
         chk("imm",       imm,              h.imm);
         chk("fu_type",   32'(fu_type),     32'(h.fu));
         chk("uses_rs1",  32'(uses_rs1),    32'(h.u1));
         chk("uses_rs2",  32'(uses_rs2),    32'(h.u2));
         chk("writes_rd", 32'(writes_rd),   32'(h.wr));
         chk("illegal",   32'(illegal),     32'(h.ill));
      end
   endtask

   task automatic cycle();
      bit   do_push, do_pop;
      exp_t e;
      check_model();
      do_push = valid_in && (q.size() != DEPTH);
      do_pop  = ready_in && (q.size() != 0);
      e = ref_dec(instr_in, pc_in, pc_4_in);
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
      end
      #1;
   endtask

   task automatic drive(logic v, logic [31:0] ins, logic [31:0] pc, logic ri, logic fl);
      valid_in = v; instr_in = ins; pc_in = pc; pc_4_in = pc + 32'd4;
      ready_in = ri; flush = fl;
   endtask

   task automatic push_one(logic [31:0] ins, logic [31:0] pc);
      drive(1'b1, ins, pc, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [31:0] r;
      logic [6:0]  ops [10];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

      reset = 1'b0;
      drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      #12;
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ready_out", 32'(ready_out), 32'd1);
      chk("rst_pc_out",    pc_out,         32'd0);
      chk("rst_imm",       imm,            32'd0);
      chk("rst_rd",        32'(rd),        32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // addi x1,x0,5
      push_one(32'h0050_0093, 32'h100);
      chk("addi_valid", 32'(valid_out), 32'd1);
      chk("addi_rd",    32'(rd),        32'd1);
      chk("addi_rs1",   32'(rs1),       32'd0);
      chk("addi_imm",   imm,            32'd5);
      chk("addi_fu",    32'(fu_type),   32'd0);
      chk("addi_wr",    32'(writes_rd), 32'd1);
      chk("addi_u2",    32'(uses_rs2),  32'd0);
      chk("addi_pc4",   pc_4_out,       32'h104);
      cycle();

      // sw x2,8(x1)
      push_one(32'h0020_A423, 32'h104);
      chk("sw_rs1", 32'(rs1),       32'd1);
      chk("sw_rs2", 32'(rs2),       32'd2);
      chk("sw_imm", imm,            32'd8);
      chk("sw_fu",  32'(fu_type),   32'd2);
      chk("sw_wr",  32'(writes_rd), 32'd0);
      chk("sw_u2",  32'(uses_rs2),  32'd1);
      cycle();

      // beq x0,x0,-4 then lui x5
      push_one(32'hFE00_0EE3, 32'h108);
      chk("beq_imm", imm,            32'hFFFF_FFFC);
      chk("beq_fu",  32'(fu_type),   32'd1);
      chk("beq_wr",  32'(writes_rd), 32'd0);
      cycle();
      push_one(32'h1234_52B7, 32'h10C);
      chk("lui_imm", imm,     32'h1234_5000);
      chk("lui_rd",  32'(rd), 32'd5);
      cycle();

      // Three beats against a stalled consumer
      drive(1'b1, 32'h0010_0113, 32'h200, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0020_0193, 32'h204, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0030_0213, 32'h208, 1'b0, 1'b0);
      chk("burst_full_ready", 32'(ready_out), 32'd0);
      cycle();
      drive(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0); cycle();
      chk("burst_head_b", pc_out, 32'h204);
      cycle();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("burst_head_c", pc_out, 32'h208);
      cycle();
      cycle();

      // Flush with a full buffer and a concurrent beat
      drive(1'b1, 32'h0050_0093, 32'h300, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0050_0093, 32'h304, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0070_0393, 32'h999, 1'b0, 1'b1); cycle();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      chk("flush_valid", 32'(valid_out), 32'd0);
      chk("flush_ready", 32'(ready_out), 32'd1);
      cycle();
      cycle();
      push_one(32'hFFFF_FFFF, 32'h400);
      chk("ill_flag", 32'(illegal),   32'd1);
      chk("ill_wr",   32'(writes_rd), 32'd0);
      cycle();

      // Asynchronous reset mid-burst
      drive(1'b1, 32'h0050_0093, 32'h500, 1'b0, 1'b0); cycle();
      drive(1'b1, 32'h0060_0113, 32'h504, 1'b0, 1'b0);
      #3 reset = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_out), 32'd0);
      chk("arst_ready", 32'(ready_out), 32'd1);
      chk("arst_pc",    pc_out,         32'd0);
      q.delete();
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      #2 reset = 1'b1;
      @(posedge clk); #1;
      push_one(32'h0050_0093, 32'h600);
      chk("post_rst_rd",  32'(rd), 32'd1);
      chk("post_rst_imm", imm,     32'd5);
      cycle();

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom();
         r[6:0] = ops[$urandom_range(9)];
         if (r[6:0] == 7'h00) r[6:0] = 7'($urandom());
         drive(1'($urandom_range(9) < 7), r, $urandom() & 32'hFFFF_FFFC,
               1'($urandom_range(9) < 6), 1'($urandom_range(19) == 0));
         cycle();
      end
      drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH + 2; i++) cycle();
      chk("drained", 32'(valid_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
